// File: rtl/dsp_r_channel_ordered.sv
// Purpose : AXI R-channel dispatcher; per-slave beat FIFOs drained to the master in AR-issue order.
// Latency : slave handshake to m_RVALID_o is 2 cycles with OUT_REG=1, 1 cycle with OUT_REG=0.
// Backpres: m_RREADY_i low fills the skid, then FIFO h; each sa_RREADY_o[k] drops only when FIFO k is full.
//
// Ports: ACLK_i/ARESET_i clock and sync active-high reset; ord_push_i/ord_slv_id_i/ord_ready_o record
// the target slave of each issued AR; sa_R*_i/sa_RREADY_o are the per-slave R channels packed slave k
// at [k*W +: W]; m_R*_o/m_RREADY_i are the master R channel; ost_cnt_o is the outstanding burst count.

// Generic circular FIFO. Pushes while full and pops while empty are ignored.
module dsp_r_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_dat_o,
    output logic [$clog2(DEPTH):0]   cnt_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    // Extra pointer bit distinguishes full from empty.
    assign cnt_o      = wptr_q - rptr_q;
    assign do_push    = push_i & (cnt_o != (AW+1)'(DEPTH));
    assign do_pop     = pop_i & (cnt_o != '0);
    assign head_dat_o = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q + (AW+1)'(do_push);
        rptr_d = rptr_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= push_dat_i;
        end
    end
endmodule

module dsp_r_channel_ordered #(
    parameter int SLV_AMT         = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int TRANS_MST_ID_W  = 5,
    parameter int TRANS_RD_RESP_W = 2,
    parameter int SLV_ID_W        = $clog2(SLV_AMT),
    parameter int DSP_RDATA_DEPTH = 16,
    parameter int OST_DEPTH       = 8,
    parameter int OUT_REG         = 1
) (
    input  logic                                  ACLK_i,
    input  logic                                  ARESET_i,
    input  logic                                  ord_push_i,
    input  logic [SLV_ID_W-1:0]                   ord_slv_id_i,
    output logic                                  ord_ready_o,
    input  logic [TRANS_MST_ID_W*SLV_AMT-1:0]     sa_RID_i,
    input  logic [DATA_WIDTH*SLV_AMT-1:0]         sa_RDATA_i,
    input  logic [TRANS_RD_RESP_W*SLV_AMT-1:0]    sa_RRESP_i,
    input  logic [SLV_AMT-1:0]                    sa_RLAST_i,
    input  logic [SLV_AMT-1:0]                    sa_RVALID_i,
    output logic [SLV_AMT-1:0]                    sa_RREADY_o,
    output logic [TRANS_MST_ID_W-1:0]             m_RID_o,
    output logic [DATA_WIDTH-1:0]                 m_RDATA_o,
    output logic [TRANS_RD_RESP_W-1:0]            m_RRESP_o,
    output logic                                  m_RLAST_o,
    output logic                                  m_RVALID_o,
    input  logic                                  m_RREADY_i,
    output logic [$clog2(OST_DEPTH+1)-1:0]        ost_cnt_o
);
    localparam int IDW = TRANS_MST_ID_W;
    localparam int RW  = TRANS_RD_RESP_W;
    // Beat payload {RID, RDATA, RRESP, RLAST}; RLAST sits at bit 0.
    localparam int PW  = IDW + DATA_WIDTH + RW + 1;
    localparam int FCW = $clog2(DSP_RDATA_DEPTH) + 1;
    localparam int OCW = $clog2(OST_DEPTH) + 1;

    logic [PW-1:0]       fifo_head [SLV_AMT];
    logic [FCW-1:0]      fifo_cnt  [SLV_AMT];
    logic [SLV_AMT-1:0]  fifo_empty;
    logic [SLV_AMT-1:0]  fifo_full;

    logic [SLV_ID_W-1:0] oq_head;
    logic [OCW-1:0]      oq_cnt;
    logic                oq_empty, oq_full, oq_pop;

    logic [PW-1:0]       sel_dat;
    logic                sel_empty;
    logic                int_vld, int_rdy, int_hs;
    logic                out_vld;
    logic [PW-1:0]       out_dat;

    // Order queue: slave ID of each issued AR, head is the slave currently owning the master R channel.
    assign oq_empty    = (oq_cnt == '0);
    assign oq_full     = (oq_cnt == OCW'(OST_DEPTH));
    assign ord_ready_o = ~oq_full & ~ARESET_i;
    assign ost_cnt_o   = oq_cnt;

    dsp_r_fifo #(.WIDTH(SLV_ID_W), .DEPTH(OST_DEPTH)) u_ord_q (
        .clk_i      (ACLK_i),
        .rst_i      (ARESET_i),
        .push_i     (ord_push_i & ord_ready_o),
        .push_dat_i (ord_slv_id_i),
        .pop_i      (oq_pop),
        .head_dat_o (oq_head),
        .cnt_o      (oq_cnt)
    );

    for (genvar k = 0; k < SLV_AMT; k++) begin : g_slv
        assign fifo_empty[k]  = (fifo_cnt[k] == '0);
        assign fifo_full[k]   = (fifo_cnt[k] == FCW'(DSP_RDATA_DEPTH));
        assign sa_RREADY_o[k] = ~fifo_full[k] & ~ARESET_i;

        dsp_r_fifo #(.WIDTH(PW), .DEPTH(DSP_RDATA_DEPTH)) u_beat_q (
            .clk_i      (ACLK_i),
            .rst_i      (ARESET_i),
            .push_i     (sa_RVALID_i[k] & sa_RREADY_o[k]),
            .push_dat_i ({sa_RID_i[k*IDW +: IDW], sa_RDATA_i[k*DATA_WIDTH +: DATA_WIDTH],
                          sa_RRESP_i[k*RW +: RW], sa_RLAST_i[k]}),
            .pop_i      (int_hs & (oq_head == SLV_ID_W'(k))),
            .head_dat_o (fifo_head[k]),
            .cnt_o      (fifo_cnt[k])
        );
    end

    // Only the head slave's FIFO is visible; other slaves keep buffering until their turn.
    always_comb begin
        sel_dat   = '0;
        sel_empty = 1'b1;
        for (int k = 0; k < SLV_AMT; k++) begin
            if (oq_head == SLV_ID_W'(k)) begin
                sel_dat   = fifo_head[k];
                sel_empty = fifo_empty[k];
            end
        end
    end

    assign int_vld = ~oq_empty & ~sel_empty;
    assign int_hs  = int_vld & int_rdy;
    // The burst's last beat retires its order entry so the next beat comes from the next slave.
    assign oq_pop  = int_hs & sel_dat[0];

    if (OUT_REG != 0) begin : g_out_reg
        logic [1:0] skid_cnt;

        // Two entries let the stage accept every cycle while the master keeps RREADY high.
        assign int_rdy = (skid_cnt != 2'd2);
        assign out_vld = (skid_cnt != 2'd0);

        dsp_r_fifo #(.WIDTH(PW), .DEPTH(2)) u_skid (
            .clk_i      (ACLK_i),
            .rst_i      (ARESET_i),
            .push_i     (int_hs),
            .push_dat_i (sel_dat),
            .pop_i      (out_vld & m_RREADY_i),
            .head_dat_o (out_dat),
            .cnt_o      (skid_cnt)
        );
    end else begin : g_out_comb
        assign int_rdy = m_RREADY_i;
        assign out_vld = int_vld;
        assign out_dat = sel_dat;
    end

    // Payload forced to zero while idle so reset and empty states present a clean bus.
    assign m_RVALID_o = out_vld;
    assign {m_RID_o, m_RDATA_o, m_RRESP_o, m_RLAST_o} = out_vld ? out_dat : '0;
endmodule

// File: tb/tb_dsp_r_channel_ordered.sv
// Purpose : scoreboard bench for dsp_r_channel_ordered; unit 0 uses OUT_REG=1, unit 1 uses OUT_REG=0.
// Latency : expected beats are queued at issue time and popped by a negedge monitor on each master handshake.
// Backpres: m_RREADY per unit is driven by the directed scenarios.
module tb_dsp_r_channel_ordered;
    typedef struct packed {
        logic [4:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst        [2];
    logic        ord_push   [2];
    logic [1:0]  ord_id     [2];
    logic        ord_rdy    [2];
    logic [19:0] sa_rid     [2];
    logic [127:0] sa_rdata  [2];
    logic [7:0]  sa_rresp   [2];
    logic [3:0]  sa_rlast   [2];
    logic [3:0]  sa_rvalid  [2];
    logic [3:0]  sa_rready  [2];
    logic [4:0]  m_rid      [2];
    logic [31:0] m_rdata    [2];
    logic [1:0]  m_rresp    [2];
    logic        m_rlast    [2];
    logic        m_rvalid   [2];
    logic        m_rready   [2];
    logic [3:0]  ost        [2];

    beat_t exp_q0[$];
    beat_t exp_q1[$];
    int    errors = 0;
    int    checks = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dsp_r_channel_ordered #(.OUT_REG(g == 0 ? 1 : 0)) u_dut (
            .ACLK_i       (clk),
            .ARESET_i     (rst[g]),
            .ord_push_i   (ord_push[g]),
            .ord_slv_id_i (ord_id[g]),
            .ord_ready_o  (ord_rdy[g]),
            .sa_RID_i     (sa_rid[g]),
            .sa_RDATA_i   (sa_rdata[g]),
            .sa_RRESP_i   (sa_rresp[g]),
            .sa_RLAST_i   (sa_rlast[g]),
            .sa_RVALID_i  (sa_rvalid[g]),
            .sa_RREADY_o  (sa_rready[g]),
            .m_RID_o      (m_rid[g]),
            .m_RDATA_o    (m_rdata[g]),
            .m_RRESP_o    (m_rresp[g]),
            .m_RLAST_o    (m_rlast[g]),
            .m_RVALID_o   (m_rvalid[g]),
            .m_RREADY_i   (m_rready[g]),
            .ost_cnt_o    (ost[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: every master handshake must match the oldest expected beat of that unit.
    always @(negedge clk) begin : mon
        beat_t got;
        beat_t want;
        logic  have;
        for (int u = 0; u < 2; u++) begin
            if (m_rvalid[u] && m_rready[u]) begin
                got  = {m_rid[u], m_rdata[u], m_rresp[u], m_rlast[u]};
                have = 1'b0;
                want = '0;
                if (u == 0) begin
                    if (exp_q0.size() > 0) begin have = 1'b1; want = exp_q0.pop_front(); end
                end else begin
                    if (exp_q1.size() > 0) begin have = 1'b1; want = exp_q1.pop_front(); end
                end
                if (!have) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected u%0d: got %h required no beat", u, got);
                end else begin
                    chk($sformatf("beat_u%0d", u), 64'(got), 64'(want));
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ord(input int u, input logic [1:0] s);
        ord_push[u] = 1'b1;
        ord_id[u]   = s;
        @(posedge clk); #1;
        ord_push[u] = 1'b0;
    endtask

    task automatic exp_beat(input int u, input logic [4:0] id, input logic [31:0] d,
                            input logic [1:0] r, input logic last);
        beat_t b;
        b = {id, d, r, last};
        if (u == 0) exp_q0.push_back(b);
        else        exp_q1.push_back(b);
    endtask

    // Presents one beat on slave k and returns just after the edge it was accepted on.
    task automatic slv_beat(input int u, input int k, input logic [4:0] id, input logic [31:0] d,
                            input logic [1:0] r, input logic last);
        int n;
        sa_rvalid[u][k]         = 1'b1;
        sa_rid[u][k*5 +: 5]     = id;
        sa_rdata[u][k*32 +: 32] = d;
        sa_rresp[u][k*2 +: 2]   = r;
        sa_rlast[u][k]          = last;
        n = 0;
        @(negedge clk);
        while (!sa_rready[u][k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL slv_beat_timeout u%0d slave %0d: sa_RREADY stayed %0b required 1", u, k, sa_rready[u][k]);
        end
        @(posedge clk); #1;
        sa_rvalid[u][k] = 1'b0;
    endtask

    task automatic burst_exp(input int u, input logic [4:0] id, input logic [31:0] base,
                             input int n, input logic [1:0] r);
        for (int i = 0; i < n; i++) exp_beat(u, id, base + 32'(i), r, i == n - 1);
    endtask

    task automatic burst_send(input int u, input int k, input logic [4:0] id, input logic [31:0] base,
                              input int first, input int n, input logic [1:0] r);
        for (int i = first; i < n; i++) slv_beat(u, k, id, base + 32'(i), r, i == n - 1);
    endtask

    task automatic wait_drain(input int u);
        int n;
        n = 0;
        @(negedge clk);
        while ((((u == 0) ? exp_q0.size() : exp_q1.size()) != 0 || m_rvalid[u]) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout u%0d: %0d beats outstanding, required 0",
                     u, (u == 0) ? exp_q0.size() : exp_q1.size());
        end
        @(posedge clk); #1;
    endtask

    // One 4-beat burst from slave 1 with RID 3, data 0x10..0x13.
    task automatic scen_single(input int u);
        push_ord(u, 2'd1);
        @(negedge clk);
        chk($sformatf("ost_after_push_u%0d", u), 64'(ost[u]), 64'd1);
        @(posedge clk); #1;
        burst_exp(u, 5'd3, 32'h10, 4, 2'd0);
        slv_beat(u, 1, 5'd3, 32'h10, 2'd0, 1'b0);
        @(negedge clk);
        if (u == 0) begin
            chk("lat_gap_u0", 64'(m_rvalid[0]), 64'd0);
            @(negedge clk);
            chk("lat_2cyc_u0", 64'(m_rvalid[0]), 64'd1);
        end else begin
            chk("lat_1cyc_u1", 64'(m_rvalid[1]), 64'd1);
        end
        @(posedge clk); #1;
        burst_send(u, 1, 5'd3, 32'h10, 1, 4, 2'd0);
        wait_drain(u);
        chk($sformatf("ost_after_burst_u%0d", u), 64'(ost[u]), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; ord_push[u] = 1'b0; ord_id[u] = '0;
            sa_rid[u] = '0; sa_rdata[u] = '0; sa_rresp[u] = '0; sa_rlast[u] = '0; sa_rvalid[u] = '0;
            m_rready[u] = 1'b1;
        end
        cyc(3);

        // Reset state.
        @(negedge clk);
        chk("rst_sa_rready", 64'(sa_rready[0]), 64'h0);
        chk("rst_ord_ready", 64'(ord_rdy[0]), 64'd0);
        chk("rst_m_rvalid", 64'(m_rvalid[0]), 64'd0);
        chk("rst_ost", 64'(ost[0]), 64'd0);
        chk("rst_m_rdata", 64'(m_rdata[0]), 64'd0);
        @(posedge clk); #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        chk("rel_sa_rready", 64'(sa_rready[0]), 64'hF);
        chk("rel_ord_ready", 64'(ord_rdy[0]), 64'd1);
        @(posedge clk); #1;

        // Single burst, registered output.
        scen_single(0);

        // Order 2 then 0; slave 0 answers first but must wait for slave 2's RLAST.
        push_ord(0, 2'd2);
        push_ord(0, 2'd0);
        burst_exp(0, 5'd7, 32'h20, 2, 2'd0);
        burst_exp(0, 5'd1, 32'h30, 2, 2'd2);
        burst_send(0, 0, 5'd1, 32'h30, 0, 2, 2'd2);
        cyc(4);
        @(negedge clk);
        chk("nonhead_held", 64'(m_rvalid[0]), 64'd0);
        chk("ost_two", 64'(ost[0]), 64'd2);
        @(posedge clk); #1;
        burst_send(0, 2, 5'd7, 32'h20, 0, 2, 2'd0);
        wait_drain(0);

        // Master stall during an 18-beat burst: skid (2) + FIFO (16) absorb it all, then slave 1 stalls.
        m_rready[0] = 1'b0;
        push_ord(0, 2'd1);
        burst_exp(0, 5'd4, 32'h100, 18, 2'd1);
        burst_send(0, 1, 5'd4, 32'h100, 0, 18, 2'd1);
        @(negedge clk);
        chk("stall_sa_rready1", 64'(sa_rready[0][1]), 64'd0);
        chk("stall_other_rready", 64'(sa_rready[0]), 64'hD);
        chk("stall_m_rvalid", 64'(m_rvalid[0]), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_rdata_stable", 64'(m_rdata[0]), 64'h100);
        end
        @(posedge clk); #1;
        m_rready[0] = 1'b1;
        wait_drain(0);
        chk("ost_after_stall", 64'(ost[0]), 64'd0);

        // Fill the order queue, then push while the head retires.
        push_ord(0, 2'd3);
        push_ord(0, 2'd0);
        push_ord(0, 2'd1);
        push_ord(0, 2'd2);
        push_ord(0, 2'd3);
        push_ord(0, 2'd0);
        push_ord(0, 2'd1);
        push_ord(0, 2'd2);
        @(negedge clk);
        chk("oq_full_ready", 64'(ord_rdy[0]), 64'd0);
        chk("oq_full_ost", 64'(ost[0]), 64'd8);
        @(posedge clk); #1;
        exp_beat(0, 5'd9, 32'h55, 2'd0, 1'b1);
        slv_beat(0, 3, 5'd9, 32'h55, 2'd0, 1'b1);
        ord_push[0] = 1'b1;
        ord_id[0]   = 2'd1;
        @(posedge clk); #1;
        ord_push[0] = 1'b0;
        @(negedge clk);
        chk("push_pop_full_ost", 64'(ost[0]), 64'd7);
        chk("push_pop_full_ready", 64'(ord_rdy[0]), 64'd1);
        @(posedge clk); #1;

        // Reset during the 2nd beat of slave 0's burst (slave 0 is now head).
        exp_beat(0, 5'd2, 32'h60, 2'd3, 1'b0);
        slv_beat(0, 0, 5'd2, 32'h60, 2'd3, 1'b0);
        cyc(2);
        sa_rvalid[0][0]    = 1'b1;
        sa_rdata[0][31:0]  = 32'h61;
        sa_rlast[0][0]     = 1'b1;
        rst[0]             = 1'b1;
        @(negedge clk);
        chk("rst_mid_comb_rready", 64'(sa_rready[0]), 64'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_m_rvalid", 64'(m_rvalid[0]), 64'd0);
        chk("rst_mid_ost", 64'(ost[0]), 64'd0);
        chk("rst_mid_sa_rready", 64'(sa_rready[0]), 64'h0);
        chk("rst_mid_ord_ready", 64'(ord_rdy[0]), 64'd0);
        @(posedge clk); #1;
        rst[0]       = 1'b0;
        sa_rvalid[0] = '0;
        @(negedge clk);
        chk("rst_rel_sa_rready", 64'(sa_rready[0]), 64'hF);
        chk("rst_rel_m_rvalid", 64'(m_rvalid[0]), 64'd0);
        @(posedge clk); #1;
        push_ord(0, 2'd2);
        exp_beat(0, 5'h1F, 32'hABCD_0001, 2'd0, 1'b1);
        slv_beat(0, 2, 5'h1F, 32'hABCD_0001, 2'd0, 1'b1);
        wait_drain(0);
        chk("ost_after_fresh", 64'(ost[0]), 64'd0);

        // Combinational output unit, same single burst.
        scen_single(1);

        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dsp_r_channel_ordered.md
# dsp_r_channel_ordered

AXI read-data (R) channel dispatcher for the interconnect master port. It buffers R beats per slave in one FIFO per slave and returns them to the master in AR-issue order. Issue order is held in an internal slave-ID order queue, so several read bursts can be outstanding across different slaves. It replaces the externally-steered single-outstanding R dispatcher and adds an optional registered output stage.

## Interface
Parameters:
- SLV_AMT, 4, number of slaves (≥2)
- DATA_WIDTH, 32, RDATA width
- TRANS_MST_ID_W, 5, RID width
- TRANS_RD_RESP_W, 2, RRESP width
- SLV_ID_W, $clog2(SLV_AMT), slave index width
- DSP_RDATA_DEPTH, 16, per-slave beat FIFO depth (power of two, ≥2)
- OST_DEPTH, 8, order-queue depth = max outstanding bursts (power of two, ≥2)
- OUT_REG, 1, 1 = 2-entry registered skid stage on the master side; 0 = combinational output

Ports:
- ACLK_i  in  1  clock
- ARESET_i  in  1  synchronous, active-high reset
- ord_push_i  in  1  AR handshake occurred; push ord_slv_id_i
- ord_slv_id_i  in  SLV_ID_W  target slave of that AR
- ord_ready_o  out  1  order queue can accept a push
- sa_RID_i  in  TRANS_MST_ID_W*SLV_AMT  per-slave RID, slave k at bits [k*W +: W]
- sa_RDATA_i  in  DATA_WIDTH*SLV_AMT  per-slave RDATA
- sa_RRESP_i  in  TRANS_RD_RESP_W*SLV_AMT  per-slave RRESP
- sa_RLAST_i  in  SLV_AMT  per-slave RLAST
- sa_RVALID_i  in  SLV_AMT  per-slave RVALID
- sa_RREADY_o  out  SLV_AMT  per-slave RREADY
- m_RID_o / m_RDATA_o / m_RRESP_o / m_RLAST_o  out  matching widths  master R payload
- m_RVALID_o  out  1  master RVALID
- m_RREADY_i  in  1  master RREADY
- ost_cnt_o  out  $clog2(OST_DEPTH+1)  number of bursts in the order queue

## Operation
- Per-slave FIFO k:
  - Write on sa_RVALID_i[k] & sa_RREADY_o[k]; sa_RREADY_o[k] = ~full[k] & ~ARESET_i.
  - Payload is {RID, RDATA, RRESP, RLAST}.
- Order queue:
  - Push on ord_push_i & ord_ready_o; ord_ready_o = ~oq_full & ~ARESET_i.
  - A push while full is dropped. An upstream AR dispatcher must stall on ord_ready_o=0.
- Selection: head slave h = oq_head when oq not empty. Internal valid = ~oq_empty & ~empty[h].
- Beat transfer: internal handshake pops FIFO h. If the popped beat has RLAST=1, the order-queue head is popped in the same cycle, and the next beat is taken from the next queued slave.
- Beats from non-head slaves stay buffered. Non-head slaves stall only when their own FIFO is full.
- OUT_REG=1: 2-entry skid buffer between the internal selection and the m_R* ports. Throughput is 1 beat/cycle under continuous m_RREADY_i.
- OUT_REG=0: m_R* ports are driven combinationally from the FIFO h head.
- ost_cnt_o increments on push, decrements on RLAST pop, and is unchanged when both happen in the same cycle.
- Simultaneous push and pop on a full order queue: the push is refused (ord_ready_o already 0) and the pop proceeds.
- RLAST on a slave whose ID is not at the queue head: the beat stays buffered; there is no reordering.

## Timing
- Reset (ARESET_i=1 at a rising edge): all FIFOs empty, order queue empty, skid stage empty, ost_cnt_o=0, m_RVALID_o=0, m_R* payload=0.
- While ARESET_i=1, sa_RREADY_o=0 and ord_ready_o=0. Both rise combinationally in the first cycle after release.
- Reset mid-burst discards all buffered beats and order entries.
- FIFO write latency: a beat written at edge N is visible at the FIFO head after edge N.
- An order push at edge N is selectable after edge N.
- Beat ingress to master: OUT_REG=1 gives m_RVALID_o 2 cycles after the slave handshake edge; OUT_REG=0 gives 1 cycle.
- m_RVALID_o, once high, holds with a stable payload until m_RREADY_i=1 (AXI rule). This holds in both modes, because the FIFO head only pops on a handshake.
- Full boundary: FIFO k full forces sa_RREADY_o[k]=0 in the same cycle. A read and a refused write in the same cycle leave the FIFO no longer full after the edge.

## Test plan
- Single slave 1, one 4-beat burst (RID=3, data 0x10..0x13), m_RREADY=1 -> 4 master beats in order, RLAST on the 4th, ost_cnt_o goes 1→0, and m_RVALID_o rises 2 cycles after the first slave beat (OUT_REG=1).
- Order 2 then 0: slave 0 returns a 2-beat burst before slave 2 returns its 2-beat burst -> master sees slave 2's beats first, then slave 0's. Slave 0's beats are held until slave 2's RLAST.
- m_RREADY_i=0 for 20 cycles during an 18-beat burst from slave 1 (DEPTH=16) -> sa_RREADY_o[1]=0 after 16 beats plus the skid occupancy. No beat is lost or duplicated, and RDATA is stable while stalled.
- Push 8 orders without returns (OST_DEPTH=8) -> ord_ready_o=0 and ost_cnt_o=8. A push and an RLAST pop in the same cycle give ost_cnt_o=7 and the push is dropped.
- ARESET_i asserted in the middle of the 2nd beat of a burst -> the next cycle shows m_RVALID_o=0, ost_cnt_o=0, and all sa_RREADY_o=0. After release, a fresh 1-beat burst passes correctly.
- OUT_REG=0 regression of the first scenario -> same beats, with m_RVALID_o 1 cycle after the slave handshake.
